// File: rtl/ahb_decoder_mux.sv
// AHB address decoder and response multiplexer between the arbitrated mainbus and N subordinates.
// Optional error counter enabled by defining AHB_DECODER_ERRCNT_EN.
module ahb_decoder_mux #(
  parameter int unsigned SUBORDINATES = 4,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [SUBORDINATES*ADDR_WIDTH-1:0] SUB_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [SUBORDINATES*ADDR_WIDTH-1:0] SUB_MASK = {4{32'hF000_0000}}
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  // mainbus (subordinate side of the arbiter output)
  input  logic [ADDR_WIDTH-1:0]              mainbus_haddr_i,
  input  logic                               mainbus_hwrite_i,
  input  logic [2:0]                         mainbus_hsize_i,
  input  logic [1:0]                         mainbus_htrans_i,
  input  logic [2:0]                         mainbus_hburst_i,
  input  logic [DATA_WIDTH-1:0]              mainbus_hwdata_i,
  output logic [DATA_WIDTH-1:0]              mainbus_hrdata_o,
  output logic                               mainbus_hresp_o,
  output logic                               mainbus_hready_o,
  // subordinate buses, address phase broadcast to all
  output logic [ADDR_WIDTH-1:0]              subs_haddr_o,
  output logic                               subs_hwrite_o,
  output logic [2:0]                         subs_hsize_o,
  output logic [1:0]                         subs_htrans_o,
  output logic [2:0]                         subs_hburst_o,
  output logic [DATA_WIDTH-1:0]              subs_hwdata_o,
  input  logic [SUBORDINATES*DATA_WIDTH-1:0] subs_hrdata_i,
  input  logic [SUBORDINATES-1:0]            subs_hresp_i,
  input  logic [SUBORDINATES-1:0]            subs_hready_i,
  output logic [SUBORDINATES-1:0]            hsel,
  output logic                               hready_bcast
`ifdef AHB_DECODER_ERRCNT_EN
  ,
  input  logic                               err_clr,
  output logic [15:0]                        err_count
`endif
);

  localparam int unsigned SelW = $clog2(SUBORDINATES + 1);
  localparam logic [SelW-1:0] DefSel = SelW'(SUBORDINATES);

  typedef enum logic [1:0] {StIdle, StErr1, StErr2} ds_state_e;

  logic [SelW-1:0] dsel_q, dsel_d;
  logic            dact_q, dact_d;
  ds_state_e       ds_q, ds_d;
  logic [SelW-1:0] match_idx;
  logic            match_hit;
  logic            trans_active;
  logic            err_accept;
  logic            ds_ready;
  logic            ds_resp;

  assign subs_haddr_o  = mainbus_haddr_i;
  assign subs_hwrite_o = mainbus_hwrite_i;
  assign subs_hsize_o  = mainbus_hsize_i;
  assign subs_htrans_o = mainbus_htrans_i;
  assign subs_hburst_o = mainbus_hburst_i;
  assign subs_hwdata_o = mainbus_hwdata_i;
  assign hready_bcast  = mainbus_hready_o;

  // NONSEQ (2'b10) and SEQ (2'b11) both have bit 1 set
  assign trans_active = mainbus_htrans_i[1];
  assign err_accept   = mainbus_hready_o && trans_active && !match_hit;

  // Lowest matching index wins when regions overlap
  always_comb begin
    match_hit = 1'b0;
    match_idx = DefSel;
    for (int unsigned i = 0; i < SUBORDINATES; i++) begin
      if (!match_hit && ((mainbus_haddr_i & SUB_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                         SUB_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        match_hit = 1'b1;
        match_idx = SelW'(i);
      end
    end
  end

  always_comb begin
    hsel = '0;
    for (int unsigned i = 0; i < SUBORDINATES; i++) begin
      hsel[i] = match_hit && (match_idx == SelW'(i));
    end
  end

  always_comb begin
    dsel_d = dsel_q;
    dact_d = dact_q;
    if (mainbus_hready_o) begin
      dsel_d = match_idx;
      dact_d = trans_active;
    end
  end

  always_comb begin
    ds_d     = ds_q;
    ds_ready = 1'b1;
    ds_resp  = 1'b0;
    unique case (ds_q)
      StIdle: if (err_accept) ds_d = StErr1;
      StErr1: begin
        ds_ready = 1'b0;
        ds_resp  = 1'b1;
        ds_d     = StErr2;
      end
      StErr2: begin
        ds_resp = 1'b1;
        ds_d    = err_accept ? StErr1 : StIdle;
      end
      default: ds_d = StIdle;
    endcase
  end

  always_comb begin
    mainbus_hready_o = 1'b1;
    mainbus_hresp_o  = 1'b0;
    mainbus_hrdata_o = '0;
    if (dact_q) begin
      if (dsel_q == DefSel) begin
        mainbus_hready_o = ds_ready;
        mainbus_hresp_o  = ds_resp;
      end else begin
        for (int unsigned i = 0; i < SUBORDINATES; i++) begin
          if (dsel_q == SelW'(i)) begin
            mainbus_hready_o = subs_hready_i[i];
            mainbus_hresp_o  = subs_hresp_i[i];
            mainbus_hrdata_o = subs_hrdata_i[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q <= DefSel;
      dact_q <= 1'b0;
      ds_q   <= StIdle;
    end else begin
      dsel_q <= dsel_d;
      dact_q <= dact_d;
      ds_q   <= ds_d;
    end
  end

`ifdef AHB_DECODER_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // StErr1 never holds, so every cycle heading into it is a fresh entry
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if ((ds_d == StErr1) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Randomised bench for ahb_decoder_mux against a transaction-level reference model.
module tb_ahb_decoder_mux;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [1:0]    htrans;
  logic [2:0]    hburst;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hresp;
  logic          hready;
  logic [AW-1:0] s_haddr;
  logic          s_hwrite;
  logic [2:0]    s_hsize;
  logic [1:0]    s_htrans;
  logic [2:0]    s_hburst;
  logic [DW-1:0] s_hwdata;
  logic [N*DW-1:0] s_hrdata;
  logic [N-1:0]  s_hresp;
  logic [N-1:0]  s_hready;
  logic [N-1:0]  hsel;
  logic          hready_bcast;
`ifdef AHB_DECODER_ERRCNT_EN
  logic          err_clr;
  logic [15:0]   err_count;
`endif

  always #5 HCLK = ~HCLK;

  ahb_decoder_mux dut (
    .HCLK             (HCLK),
    .HRESETn          (HRESETn),
    .mainbus_haddr_i  (haddr),
    .mainbus_hwrite_i (hwrite),
    .mainbus_hsize_i  (hsize),
    .mainbus_htrans_i (htrans),
    .mainbus_hburst_i (hburst),
    .mainbus_hwdata_i (hwdata),
    .mainbus_hrdata_o (hrdata),
    .mainbus_hresp_o  (hresp),
    .mainbus_hready_o (hready),
    .subs_haddr_o     (s_haddr),
    .subs_hwrite_o    (s_hwrite),
    .subs_hsize_o     (s_hsize),
    .subs_htrans_o    (s_htrans),
    .subs_hburst_o    (s_hburst),
    .subs_hwdata_o    (s_hwdata),
    .subs_hrdata_i    (s_hrdata),
    .subs_hresp_i     (s_hresp),
    .subs_hready_i    (s_hready),
    .hsel             (hsel),
    .hready_bcast     (hready_bcast)
`ifdef AHB_DECODER_ERRCNT_EN
    ,
    .err_clr          (err_clr),
    .err_count        (err_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the transfer currently in its data phase.
  // pend = -1 none, 0..N-1 subordinate, N default subordinate (err_ph 1 or 2)
  int pend      = -1;
  int err_ph    = 0;
  int err_cnt_m = 0;

  logic [31:0] base_m [N] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
  logic [31:0] mask_m [N] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++) begin
      if ((a & mask_m[i]) == base_m[i]) return i;
    end
    return -1;
  endfunction

  // One bus cycle: drive, check combinational outputs, clock, advance the model
  task automatic step(input logic [31:0] addr, input logic [1:0] trans, input logic wr,
                      input logic [N-1:0] rdy);
    int          idx;
    logic        exp_rdy;
    logic        exp_resp;
    logic [31:0] exp_data;
    logic [N-1:0] exp_hsel;
    logic        clr;
    haddr    = addr;
    htrans   = trans;
    hwrite   = wr;
    hsize    = 3'($urandom_range(0, 2));
    hburst   = 3'($urandom_range(0, 7));
    hwdata   = $urandom;
    s_hready = rdy;
    s_hresp  = N'($urandom);
    for (int i = 0; i < N; i++) s_hrdata[i*DW +: DW] = $urandom;
    clr = 1'b0;
`ifdef AHB_DECODER_ERRCNT_EN
    clr     = ($urandom_range(0, 15) == 0);
    err_clr = clr;
`endif
    #2;
    idx = decode(addr);
    exp_hsel = '0;
    if (idx >= 0) exp_hsel[idx] = 1'b1;
    if (pend < 0) begin
      exp_rdy = 1'b1; exp_resp = 1'b0; exp_data = '0;
    end else if (pend < N) begin
      exp_rdy = rdy[pend]; exp_resp = s_hresp[pend]; exp_data = s_hrdata[pend*DW +: DW];
    end else begin
      exp_rdy = (err_ph == 2); exp_resp = 1'b1; exp_data = '0;
    end
    check_eq("hsel", 64'(hsel), 64'(exp_hsel));
    check_eq("hready", 64'(hready), 64'(exp_rdy));
    check_eq("hresp", 64'(hresp), 64'(exp_resp));
    check_eq("hrdata", 64'(hrdata), 64'(exp_data));
    check_eq("hready_bcast", 64'(hready_bcast), 64'(exp_rdy));
    check_eq("bcast_addr", {s_htrans, s_hwrite, s_hsize, s_hburst, s_haddr},
             {trans, wr, hsize, hburst, addr});
    check_eq("bcast_hwdata", 64'(s_hwdata), 64'(hwdata));
`ifdef AHB_DECODER_ERRCNT_EN
    check_eq("err_count", 64'(err_count), 64'(err_cnt_m));
`endif
    @(posedge HCLK);
    if (exp_rdy) begin
      if (!trans[1]) begin
        pend = -1;
      end else if (idx >= 0) begin
        pend = idx;
      end else begin
        pend = N; err_ph = 1;
      end
    end else if (pend == N) begin
      err_ph = 2;
    end
    if (clr) err_cnt_m = 0;
    else if (exp_rdy && trans[1] && idx < 0 && err_cnt_m < 65535) err_cnt_m++;
    #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [N-1:0] rdy;
    HRESETn  = 1'b0;
    haddr    = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; hburst = '0; hwdata = '0;
    s_hready = '1; s_hresp = '0; s_hrdata = '0;
`ifdef AHB_DECODER_ERRCNT_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(posedge HCLK);
    #1;
    check_eq("rst_hready", 64'(hready), 64'd1);
    check_eq("rst_hresp", 64'(hresp), 64'd0);
    check_eq("rst_hrdata", 64'(hrdata), 64'd0);
    check_eq("rst_bcast", 64'(hready_bcast), 64'd1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Zero-wait read from subordinate 1
    step(32'h1000_0040, 2'b10, 1'b0, '1);
    step(32'h0000_0000, 2'b00, 1'b0, '1);
    // Write to subordinate 2 with two wait states, then a read to subordinate 0
    step(32'h2000_0000, 2'b10, 1'b1, '1);
    step(32'h0000_0010, 2'b10, 1'b0, 4'b1011);
    step(32'h0000_0010, 2'b10, 1'b0, 4'b1011);
    step(32'h0000_0010, 2'b10, 1'b0, '1);
    step(32'h0000_0000, 2'b00, 1'b0, '1);
    // Unmapped access followed by subordinate 3
    step(32'h4000_0000, 2'b10, 1'b0, '1);
    step(32'h3000_0000, 2'b10, 1'b0, '1);
    step(32'h3000_0000, 2'b10, 1'b0, '1);
    step(32'h0000_0000, 2'b00, 1'b0, '1);
    // Back-to-back unmapped accesses, second one taken in the ERR2 cycle
    step(32'h4000_0000, 2'b10, 1'b0, '1);
    step(32'h5000_0000, 2'b11, 1'b0, '1);
    step(32'h5000_0000, 2'b11, 1'b0, '1);
    step(32'h0000_0000, 2'b00, 1'b0, '1);
    step(32'h0000_0000, 2'b00, 1'b0, '1);
    step(32'h0000_0000, 2'b00, 1'b0, '1);
    // IDLE to an unmapped address
    step(32'h4000_0000, 2'b00, 1'b0, '1);
    step(32'h4000_0000, 2'b01, 1'b0, '1);
    step(32'h0000_0000, 2'b00, 1'b0, '1);

    // Reset asserted while the default subordinate is in its first ERROR cycle
    step(32'h4000_0000, 2'b10, 1'b0, '1);
    haddr = 32'h3000_0000; htrans = 2'b00; s_hready = '1;
    #1;
    check_eq("pre_rst_hready", 64'(hready), 64'd0);
    HRESETn = 1'b0;
    #1;
    check_eq("midrst_hready", 64'(hready), 64'd1);
    check_eq("midrst_hresp", 64'(hresp), 64'd0);
    check_eq("midrst_hsel", 64'(hsel), 64'b1000);
    pend = -1; err_ph = 0; err_cnt_m = 0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    step(32'h3000_0000, 2'b10, 1'b0, '1);
    step(32'h0000_0000, 2'b00, 1'b0, '1);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom;
      r[31:28] = 4'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) rdy[i] = ($urandom_range(0, 3) != 0);
      step(r, 2'($urandom), 1'($urandom), rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
